// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared constants and FSM state type for the 32-bit
//                restoring shift-subtract divider.
//                  WIDTH - operand/result width (only 32 is supported)
//                  CNT_W - width of the step counter (counts 0..31)
//                  state_t - IDLE / RUN / FINISH
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage : divider_pkg
`default_nettype wire

// File: rtl/subtractor_33.sv
`default_nettype none
// ============================================================================
//  Module      : subtractor_33
//  Description : Combinational 33-bit subtractor, o_diff = i_a - i_b.
//                o_borrow is set when i_b > i_a (unsigned), i.e. the trial
//                difference is negative and the divider must restore.
//  Ports       : i_a, i_b  [32:0] in  - minuend / subtrahend
//                o_diff    [32:0] out - difference (modulo 2^33)
//                o_borrow         out - 1 when the difference is negative
//  Revision    : 1.0 - initial release
// ============================================================================
module subtractor_33 (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    output logic [32:0] o_diff,
    output logic        o_borrow
);

    // One extra bit on top captures the borrow out of the 33-bit subtract.
    logic [33:0] w_full;

    assign w_full   = {1'b0, i_a} - {1'b0, i_b};
    assign o_diff   = w_full[32:0];
    assign o_borrow = w_full[33];

endmodule : subtractor_33
`default_nettype wire

// File: rtl/divider_32.sv
`default_nettype none
// ============================================================================
//  Module      : divider_32
//  Description : Multi-cycle 32-bit integer divider (DIV / DIVU).
//                Restoring shift-subtract, one quotient bit per clock.
//                Quotient truncates toward zero, remainder takes the sign
//                of the dividend. Divide by zero returns all-ones quotient
//                and the raw dividend as remainder.
//  Ports       : clock              in  - rising-edge clock
//                reset_n            in  - synchronous active-low reset
//                i_start            in  - request, sampled only in IDLE
//                i_is_signed        in  - 1 = DIV, 0 = DIVU
//                i_dividend  [31:0] in  - numerator
//                i_divisor   [31:0] in  - denominator
//                o_busy             out - operation in flight (RUN/FINISH)
//                o_done             out - one-cycle result-valid pulse
//                o_divide_by_zero   out - divisor was zero
//                o_quotient  [31:0] out - LO
//                o_remainder [31:0] out - HI
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_32
    import divider_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_divide_by_zero,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam logic [CNT_W-1:0] c_LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    // Partial remainder. After every step it is below the divisor, so its
    // 33rd bit is always zero; that bit exists only in the shifted trial.
    logic [WIDTH-1:0] r_rem;
    // Dividend magnitude shifting out the top while quotient bits enter at
    // the bottom. On divide-by-zero it holds the raw dividend instead.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_borrow;
    logic             w_unused_trial_msb;

    assign w_dvd_neg = i_is_signed & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_is_signed & i_divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~i_dividend + 1'b1) : i_dividend;
    assign w_dvs_mag = w_dvs_neg ? (~i_divisor + 1'b1) : i_divisor;

    assign w_shift = {r_rem, r_q[WIDTH-1]};

    subtractor_33 u_sub (
        .i_a      (w_shift),
        .i_b      ({1'b0, r_dvs}),
        .o_diff   (w_trial),
        .o_borrow (w_borrow)
    );

    // A non-negative trial is always below the divisor, so its MSB is zero.
    assign w_unused_trial_msb = w_trial[WIDTH];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state          <= ST_IDLE;
            r_cnt            <= '0;
            r_rem            <= '0;
            r_q              <= '0;
            r_dvs            <= '0;
            r_sign_q         <= 1'b0;
            r_sign_r         <= 1'b0;
            r_dbz            <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_divide_by_zero <= 1'b0;
            o_quotient       <= '0;
            o_remainder      <= '0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_sign_q         <= w_dvd_neg ^ w_dvs_neg;
                        r_sign_r         <= w_dvd_neg;
                        r_rem            <= '0;
                        r_cnt            <= '0;
                        r_dvs            <= w_dvs_mag;
                        o_busy           <= 1'b1;
                        o_divide_by_zero <= 1'b0;
                        if (i_divisor == '0) begin
                            r_dbz   <= 1'b1;
                            r_q     <= i_dividend;
                            r_state <= ST_FINISH;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_q     <= w_dvd_mag;
                            r_state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    if (!w_borrow) begin
                        r_rem <= w_trial[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_shift[WIDTH-1:0];
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST_STEP) begin
                        r_state <= ST_FINISH;
                    end
                end

                ST_FINISH: begin
                    if (r_dbz) begin
                        o_quotient       <= '1;
                        o_remainder      <= r_q;
                        o_divide_by_zero <= 1'b1;
                    end else begin
                        o_quotient  <= r_sign_q ? (~r_q + 1'b1) : r_q;
                        o_remainder <= r_sign_r ? (~r_rem + 1'b1) : r_rem;
                    end
                    o_done  <= 1'b1;
                    o_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : divider_32
`default_nettype wire

// File: tb/tb_divider_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider_32
//  Description : Self-checking bench for divider_32. Directed cases plus
//                randomized operations checked against an arithmetic model
//                (64-bit signed / unsigned division).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_32;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic        i_is_signed;
    logic [31:0] i_dividend;
    logic [31:0] i_divisor;
    logic        o_busy;
    logic        o_done;
    logic        o_divide_by_zero;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    divider_32 dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .i_start          (i_start),
        .i_is_signed      (i_is_signed),
        .i_dividend       (i_dividend),
        .i_divisor        (i_divisor),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_divide_by_zero (o_divide_by_zero),
        .o_quotient       (o_quotient),
        .o_remainder      (o_remainder)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain language-level division on widened operands.
    task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endtask

    // Issue one operation and check latency, results and handshake.
    // glitch_at > 0 re-pulses start with other operands at that step.
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input int glitch_at);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          lat;
        logic        got;
        model(sgn, a, b, eq, er, edz);
        i_is_signed = sgn;
        i_dividend  = a;
        i_divisor   = b;
        i_start     = 1'b1;
        @(posedge clock);
        #1;
        i_start = 1'b0;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        lat = 0;
        got = 1'b0;
        while (lat < 60 && !got) begin
            if (glitch_at != 0 && lat == glitch_at) begin
                i_start     = 1'b1;
                i_is_signed = ~sgn;
                i_dividend  = $urandom;
                i_divisor   = 32'd3;
            end else begin
                i_start = 1'b0;
            end
            @(posedge clock);
            #1;
            lat++;
            got = o_done;
        end
        i_start = 1'b0;
        chk("latency", lat, (b == 32'd0) ? 32'd1 : 32'd33);
        chk("quotient", o_quotient, eq);
        chk("remainder", o_remainder, er);
        chk("div_by_zero", {31'd0, o_divide_by_zero}, {31'd0, edz});
        chk("busy_at_done", {31'd0, o_busy}, 32'd0);
        @(posedge clock);
        #1;
        chk("done_single_pulse", {31'd0, o_done}, 32'd0);
        chk("quotient_held", o_quotient, eq);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        int          pulses;

        reset_n     = 1'b0;
        i_start     = 1'b0;
        i_is_signed = 1'b0;
        i_dividend  = 32'd0;
        i_divisor   = 32'd0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_dbz", {31'd0, o_divide_by_zero}, 32'd0);
        chk("rst_quotient", o_quotient, 32'd0);
        chk("rst_remainder", o_remainder, 32'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Directed cases
        run_op(1'b0, 32'd100, 32'd7, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(1'b0, 32'd5, 32'd0, 0);
        run_op(1'b0, 32'd9, 32'd3, 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd0, 0);
        run_op(1'b0, 32'd100, 32'd7, 10);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2, 3: b = ($urandom_range(0, 1) == 1) ? (32'd0 - 32'($urandom_range(1, 15)))
                                                         : 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(1, 31);
            run_op(s, a, b, 0);
        end

        // Reset in the middle of an operation
        run_op(1'b0, 32'd200, 32'd7, 0);
        i_is_signed = 1'b0;
        i_dividend  = 32'd100;
        i_divisor   = 32'd7;
        i_start     = 1'b1;
        @(posedge clock);
        #1;
        i_start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        chk("midrst_busy", {31'd0, o_busy}, 32'd0);
        chk("midrst_quotient", o_quotient, 32'd0);
        chk("midrst_remainder", o_remainder, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (o_done) pulses++;
        end
        chk("midrst_no_done", pulses, 32'd0);
        run_op(1'b0, 32'd100, 32'd7, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_divider_32
`default_nettype wire
